// File: rtl/divider_issue_unit.sv
`default_nettype none
// divider_issue_unit: valid/ready front end for the iterative divider. Launches the divider,
// waits under a watchdog, formats DIV/REM/div-by-zero results and handles flush/drain.
module divider_issue_unit #(
   parameter int XLEN    = 32,
   parameter int TAG_W   = 5,
   parameter int TIMEOUT = 40
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             opValid,
   output logic             opReady,
   input  logic             opSigned,
   input  logic             opRem,
   input  logic [TAG_W-1:0] opTag,
   input  logic [XLEN-1:0]  opDividend,
   input  logic [XLEN-1:0]  opDivisor,
   input  logic             flush,
   output logic             dividerStart,
   output logic             sign,
   output logic [XLEN-1:0]  dividendIn,
   output logic [XLEN-1:0]  divisorIn,
   input  logic             dividerDone,
   input  logic             dividerError,
   input  logic [XLEN-1:0]  quotientIn,
   input  logic [XLEN-1:0]  remainderIn,
   output logic             resValid,
   input  logic             resReady,
   output logic [XLEN-1:0]  resData,
   output logic [TAG_W-1:0] resTag,
   output logic             resDivZero,
   output logic             resTimeout,
   output logic             busy
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_WAIT    = 3'd2,
      S_SETTLE  = 3'd3,
      S_HOLD    = 3'd4,
      S_DRAIN   = 3'd5,
      S_DRAIN_T = 3'd6
   } state_t;

   state_t             state_q, state_d;
   logic               sign_q, sign_d;
   logic               rem_q, rem_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [XLEN-1:0]    dividend_q, dividend_d;
   logic [XLEN-1:0]    divisor_q, divisor_d;
   logic [XLEN-1:0]    res_data_q, res_data_d;
   logic               div_zero_q, div_zero_d;
   logic               timeout_q, timeout_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               done_seen_q, done_seen_d;
   logic               accept;
   logic               seen_now;

   // Ready is gated by resetN so nothing can be accepted while reset is held.
   assign opReady = resetN & ~flush &
                    ((state_q == S_IDLE) | ((state_q == S_HOLD) & resReady));
   assign accept  = opValid & opReady;

   assign dividerStart = (state_q == S_START);
   assign resValid     = (state_q == S_HOLD) | (state_q == S_DRAIN_T);
   assign busy         = (state_q != S_IDLE);
   assign sign         = sign_q;
   assign dividendIn   = dividend_q;
   assign divisorIn    = divisor_q;
   assign resData      = res_data_q;
   assign resTag       = tag_q;
   assign resDivZero   = div_zero_q;
   assign resTimeout   = timeout_q;

   always_comb begin
      state_d     = state_q;
      sign_d      = sign_q;
      rem_d       = rem_q;
      tag_d       = tag_q;
      dividend_d  = dividend_q;
      divisor_d   = divisor_q;
      res_data_d  = res_data_q;
      div_zero_d  = div_zero_q;
      timeout_d   = timeout_q;
      cnt_d       = cnt_q;
      done_seen_d = done_seen_q;
      seen_now    = done_seen_q | dividerDone;

      case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_START;
         end
         S_START: begin
            cnt_d       = '0;
            div_zero_d  = 1'b0;
            timeout_d   = 1'b0;
            done_seen_d = 1'b0;
            state_d     = flush ? S_DRAIN : S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (flush) begin
               // A done arriving with the flush means the divider is already idle.
               state_d = dividerDone ? S_IDLE : S_DRAIN;
            end else if (dividerDone) begin
               if (dividerError) begin
                  res_data_d = rem_q ? dividend_q : '1;
                  div_zero_d = 1'b1;
                  state_d    = S_HOLD;
               end else begin
                  state_d = S_SETTLE;
               end
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               res_data_d = '0;
               timeout_d  = 1'b1;
               state_d    = S_DRAIN_T;
            end
         end
         S_SETTLE: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               res_data_d = rem_q ? remainderIn : quotientIn;
               state_d    = S_HOLD;
            end
         end
         S_HOLD: begin
            if (flush | resReady) begin
               div_zero_d = 1'b0;
               timeout_d  = 1'b0;
               state_d    = accept ? S_START : S_IDLE;
            end
         end
         S_DRAIN: begin
            if (dividerDone) state_d = S_IDLE;
         end
         S_DRAIN_T: begin
            done_seen_d = seen_now;
            if (flush | resReady) begin
               div_zero_d = 1'b0;
               timeout_d  = 1'b0;
               state_d    = seen_now ? S_IDLE : S_DRAIN;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         sign_d     = opSigned;
         rem_d      = opRem;
         tag_d      = opTag;
         dividend_d = opDividend;
         divisor_d  = opDivisor;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= S_IDLE;
         sign_q      <= 1'b0;
         rem_q       <= 1'b0;
         tag_q       <= '0;
         dividend_q  <= '0;
         divisor_q   <= '0;
         res_data_q  <= '0;
         div_zero_q  <= 1'b0;
         timeout_q   <= 1'b0;
         cnt_q       <= '0;
         done_seen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sign_q      <= sign_d;
         rem_q       <= rem_d;
         tag_q       <= tag_d;
         dividend_q  <= dividend_d;
         divisor_q   <= divisor_d;
         res_data_q  <= res_data_d;
         div_zero_q  <= div_zero_d;
         timeout_q   <= timeout_d;
         cnt_q       <= cnt_d;
         done_seen_q <= done_seen_d;
      end
   end

endmodule
`default_nettype wire
